bpu_multislot: RTL and testbench
================================

Name: bpu_multislot

Overview:
- Parametrised next-generation branch predictor for the frontend fetch stage.
- Keeps a direct-mapped, tagged BHT/BTB with SLOTS 4-byte instruction slots per fetch block.
- Predicts the first taken slot at or after the fetch pc, so unaligned fetch pcs are also predicted.
- Has an update port with saturating-counter training and allocation, plus a hardware init/flush walker. Result is registered: 1-cycle lookup latency.

Parameters:
- XLEN, 64, width of pc and target.
- ENTRIES, 64, number of sets (power of 2, minimum 4); IDX_W = log2(ENTRIES).
- SLOTS, 2, 4-byte slots per fetch block (power of 2, 1..4); SL_W = max(1, log2(SLOTS)); block size = 4*SLOTS bytes.
- TAG_W, 16, tag bits taken from the pc directly above the index.
- CTR_W, 2, saturating counter width.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- pc  in  XLEN  fetch pc to predict.
- pc_handshake  in  1  lookup request; sampled on the rising edge.
- flush_all  in  1  one-cycle pulse: invalidate the whole table.
- upd_valid  in  1  resolved-branch update strobe.
- upd_pc  in  XLEN  pc of the resolved branch.
- upd_taken  in  1  resolved direction.
- upd_target  in  XLEN  resolved target.
- bpu_ready  out  1  table initialised; lookups and updates accepted.
- base_pc  out  XLEN  fetch-block-aligned pc of the last lookup.
- trigger_pc  out  XLEN  pc of the predicted-taken branch.
- predict_target  out  XLEN  predicted target.
- predict_valid  out  1  one-cycle pulse: taken prediction present.

Behaviour:
- Address split, with OFF = 2+SL_W:
  - slot = pc[OFF-1:2]
  - index = pc[OFF+IDX_W-1:OFF]
  - tag = pc[OFF+IDX_W+TAG_W-1:OFF+IDX_W]
- Entry per (index, slot): valid, tag, target, ctr. Predicted taken when ctr MSB = 1.
- Reset (synchronous, active-high):
  - All outputs are 0.
  - FSM enters INIT with walk counter = 0.
  - Reset asserted mid-walk or mid-operation restarts INIT from index 0.
- FSM:
  - INIT: clears valid of all slots of set[walk] each cycle and increments walk. After the clear of ENTRIES-1, goes to RUN. Takes ENTRIES cycles.
  - RUN: bpu_ready = 1.
  - flush_all in RUN goes to INIT with walk = 0; bpu_ready drops the next cycle.
  - flush_all during INIT restarts walk at 0.
- INIT behaviour: pc_handshake and upd_valid are ignored, and predict_valid stays 0.
- Lookup, RUN with pc_handshake = 1 in cycle N:
  - Outputs are registered and valid in cycle N+1. predict_valid is high for exactly one cycle.
  - Candidate slots s satisfy s >= slot(pc), valid, tag match and ctr MSB = 1. The lowest such s wins.
  - Outputs: base_pc = pc with bits [OFF-1:0] cleared; trigger_pc = base_pc + 4*s; predict_target = stored target.
  - Unaligned fetch: slots below slot(pc) are never selected.
  - No winner: predict_valid = 0. base_pc is still updated; trigger_pc and predict_target hold their previous values.
  - pc_handshake = 0: predict_valid = 0 next cycle, and all other outputs hold.
  - flush_all in the same cycle as a handshake: the lookup reads pre-flush contents.
- Update, RUN with upd_valid = 1, written at the edge:
  - Hit (valid and tag match): ctr increments when taken and decrements when not taken, saturating at 2^CTR_W-1 and 0. Target is overwritten only when taken.
  - Miss and taken: allocate (replace unconditionally) with valid = 1, new tag, target, ctr = 2^(CTR_W-1) (weakly taken).
  - Miss and not taken: no change.
  - flush_all and upd_valid in the same cycle: flush wins and the update is dropped.
- Lookup and update in the same cycle to the same entry: the lookup sees pre-update contents unless BPU_FWD_EN is defined.
- Widths: trigger_pc addition wraps modulo 2^XLEN. Upper pc bits not used by the tag are ignored, so aliasing is permitted.

Optional Feature:
- Macro: BPU_FWD_EN.
- Defined: a same-cycle update whose index and tag both equal those of the lookup pc is forwarded into the lookup for that slot. The lookup uses the post-update valid, ctr and target, so an allocation or train-to-taken is predicted immediately.
- Undefined: the lookup always reads array contents from before the edge. Adds no logic.

Test Plan:
- Reset then init, with ENTRIES = 64: assert reset for 2 cycles, then release. bpu_ready = 0 for 64 cycles and 1 in cycle 65. Lookups during INIT give predict_valid = 0.
- Allocate and predict: update pc = 0x8000_0004, taken, target 0x8000_0100. Then lookup pc 0x8000_0000 -> next cycle predict_valid = 1, base_pc 0x8000_0000, trigger_pc 0x8000_0004, predict_target 0x8000_0100.
- Unaligned skip, SLOTS = 2: slot 0 of 0x8000_0000 trained taken to 0x9000. Lookup pc 0x8000_0004 -> predict_valid = 0. Lookup 0x8000_0000 -> trigger_pc 0x8000_0000, target 0x9000.
- Counter saturation: after allocation (ctr = 2), apply 3 taken updates then lookup -> taken. Then 2 not-taken updates -> ctr = 1, lookup gives predict_valid = 0. Then 5 more not-taken -> ctr stays 0.
- Tag miss and flush: with 0x8000_0000 allocated, lookup 0x8000_0000 + (ENTRIES*8) -> predict_valid = 0. Pulse flush_all -> bpu_ready low for 64 cycles, after which the original pc misses.
- Same-cycle update and lookup, same pc 0x8000_0004, miss, taken: predict_valid = 0 without BPU_FWD_EN and 1 with it. Also assert reset mid-INIT at walk = 30 -> the walk restarts and bpu_ready rises 64 cycles after release.

Source files
------------

// File: rtl/bpu_multislot.sv
// Multi-slot tagged BHT/BTB predictor: first taken slot at/after the fetch pc, 1-cycle lookup.
// Optional macro BPU_FWD_EN forwards a same-cycle update into the lookup of the same entry.
module bpu_multislot #(
  parameter int XLEN    = 64,
  parameter int ENTRIES = 64,
  parameter int SLOTS   = 2,
  parameter int TAG_W   = 16,
  parameter int CTR_W   = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  input  logic            pc_handshake,
  input  logic            flush_all,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  output logic            bpu_ready,
  output logic [XLEN-1:0] base_pc,
  output logic [XLEN-1:0] trigger_pc,
  output logic [XLEN-1:0] predict_target,
  output logic            predict_valid
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int SL_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int OFF   = 2 + SL_W;
  localparam int TOP   = OFF + IDX_W + TAG_W;
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1) << (CTR_W - 1);

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] walk_q, walk_d;

  logic [SLOTS-1:0] vld_q [ENTRIES];
  logic [TAG_W-1:0] tag_q [ENTRIES][SLOTS];
  logic [XLEN-1:0]  tgt_q [ENTRIES][SLOTS];
  logic [CTR_W-1:0] ctr_q [ENTRIES][SLOTS];

  logic [XLEN-1:0] base_q, trig_q, ptgt_q;
  logic            pv_q;

  // Address fields
  logic [SL_W-1:0]  l_slot, u_slot;
  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic [XLEN-1:0]  l_base;

  assign l_slot = (SLOTS == 1) ? '0 : pc[OFF-1:2];
  assign u_slot = (SLOTS == 1) ? '0 : upd_pc[OFF-1:2];
  assign l_idx  = pc[OFF+IDX_W-1:OFF];
  assign u_idx  = upd_pc[OFF+IDX_W-1:OFF];
  assign l_tag  = pc[TOP-1:OFF+IDX_W];
  assign u_tag  = upd_pc[TOP-1:OFF+IDX_W];

  always_comb begin
    l_base = pc;
    l_base[OFF-1:0] = '0;
  end

  logic unused_bits;
  assign unused_bits = ^{pc[XLEN-1:TOP], pc[1:0], upd_pc[XLEN-1:TOP], upd_pc[1:0]};

  // FSM: init/flush walker
  always_comb begin
    state_d = state_q;
    walk_d  = walk_q;
    case (state_q)
      S_INIT: begin
        if (flush_all) walk_d = '0;
        else begin
          walk_d = walk_q + 1'b1;
          if (walk_q == IDX_W'(ENTRIES - 1)) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (flush_all) begin
          state_d = S_INIT;
          walk_d  = '0;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_INIT;
      walk_q  <= '0;
    end else begin
      state_q <= state_d;
      walk_q  <= walk_d;
    end
  end

  assign bpu_ready = (state_q == S_RUN);

  // Update: train on hit, allocate on taken miss; a flush in the same cycle drops it
  logic             u_hit, upd_we;
  logic [CTR_W-1:0] u_ctr_old, u_ctr_d;
  logic [XLEN-1:0]  u_tgt_d;

  assign u_hit     = vld_q[u_idx][u_slot] && (tag_q[u_idx][u_slot] == u_tag);
  assign u_ctr_old = ctr_q[u_idx][u_slot];

  always_comb begin
    upd_we  = 1'b0;
    u_ctr_d = u_ctr_old;
    u_tgt_d = tgt_q[u_idx][u_slot];
    if (bpu_ready && upd_valid && !flush_all && !reset) begin
      if (u_hit) begin
        upd_we = 1'b1;
        if (upd_taken) begin
          u_tgt_d = upd_target;
          if (u_ctr_old != CTR_MAX) u_ctr_d = u_ctr_old + 1'b1;
        end else if (u_ctr_old != '0) begin
          u_ctr_d = u_ctr_old - 1'b1;
        end
      end else if (upd_taken) begin
        upd_we  = 1'b1;
        u_ctr_d = CTR_INIT;
        u_tgt_d = upd_target;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (state_q == S_INIT) begin
      vld_q[walk_q] <= '0;
    end else if (upd_we) begin
      vld_q[u_idx][u_slot] <= 1'b1;
      tag_q[u_idx][u_slot] <= u_tag;
      tgt_q[u_idx][u_slot] <= u_tgt_d;
      ctr_q[u_idx][u_slot] <= u_ctr_d;
    end
  end

  // Per-slot candidate evaluation
  logic [SLOTS-1:0]           cand;
  logic [SLOTS-1:0][XLEN-1:0] rd_tgt;

  for (genvar s = 0; s < SLOTS; s++) begin : g_slot
    logic             hit;
    logic [CTR_W-1:0] ctr;
`ifdef BPU_FWD_EN
    logic fwd;
    assign fwd       = upd_we && (u_idx == l_idx) && (u_tag == l_tag) && (u_slot == SL_W'(s));
    assign hit       = fwd || (vld_q[l_idx][s] && (tag_q[l_idx][s] == l_tag));
    assign ctr       = fwd ? u_ctr_d : ctr_q[l_idx][s];
    assign rd_tgt[s] = fwd ? u_tgt_d : tgt_q[l_idx][s];
`else
    assign hit       = vld_q[l_idx][s] && (tag_q[l_idx][s] == l_tag);
    assign ctr       = ctr_q[l_idx][s];
    assign rd_tgt[s] = tgt_q[l_idx][s];
`endif
    assign cand[s] = hit && ctr[CTR_W-1] && (SL_W'(s) >= l_slot);
  end

  // Lowest candidate slot wins
  logic            win;
  logic [SL_W-1:0] win_s;
  logic [XLEN-1:0] win_tgt;

  always_comb begin
    win     = 1'b0;
    win_s   = '0;
    win_tgt = '0;
    for (int s = SLOTS - 1; s >= 0; s--) begin
      if (cand[s]) begin
        win     = 1'b1;
        win_s   = SL_W'(s);
        win_tgt = rd_tgt[s];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      base_q <= '0;
      trig_q <= '0;
      ptgt_q <= '0;
      pv_q   <= 1'b0;
    end else begin
      pv_q <= 1'b0;
      if (bpu_ready && pc_handshake) begin
        base_q <= l_base;
        pv_q   <= win;
        if (win) begin
          trig_q <= l_base + (XLEN'(win_s) << 2);
          ptgt_q <= win_tgt;
        end
      end
    end
  end

  assign base_pc        = base_q;
  assign trigger_pc     = trig_q;
  assign predict_target = ptgt_q;
  assign predict_valid  = pv_q;
endmodule

// File: tb/tb_bpu_multislot.sv
// Scoreboard bench for bpu_multislot with default parameters (ENTRIES=64, SLOTS=2).
module tb_bpu_multislot;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] pc = '0;
  logic        pc_handshake = 1'b0;
  logic        flush_all = 1'b0;
  logic        upd_valid = 1'b0;
  logic [63:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [63:0] upd_target = '0;
  logic        bpu_ready;
  logic [63:0] base_pc, trigger_pc, predict_target;
  logic        predict_valid;

  bpu_multislot dut (
    .clock(clock), .reset(reset), .pc(pc), .pc_handshake(pc_handshake),
    .flush_all(flush_all), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target), .bpu_ready(bpu_ready),
    .base_pc(base_pc), .trigger_pc(trigger_pc), .predict_target(predict_target),
    .predict_valid(predict_valid)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        pv;
    logic [63:0] base, trig, tgt;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          fails = 0;
  logic [63:0] last_trig = '0, last_tgt = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input logic [63:0] a, input bit pv, input logic [63:0] trig,
                          input logic [63:0] tgt);
    exp_t e;
    if (pv) begin
      last_trig = trig;
      last_tgt  = tgt;
    end
    e.pv   = pv;
    e.base = a & ~64'h7;
    e.trig = last_trig;
    e.tgt  = last_tgt;
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, ".pv"}, 64'(predict_valid), 64'(e.pv));
      chk({tag, ".base"}, base_pc, e.base);
      chk({tag, ".trig"}, trigger_pc, e.trig);
      chk({tag, ".tgt"}, predict_target, e.tgt);
    end
  endtask

  task automatic lookup(input string tag, input logic [63:0] a, input bit pv,
                        input logic [63:0] trig, input logic [63:0] tgt);
    push_exp(a, pv, trig, tgt);
    pc = a;
    pc_handshake = 1'b1;
    cyc();
    pc_handshake = 1'b0;
    check_out(tag);
  endtask

  task automatic upd(input logic [63:0] a, input bit tk, input logic [63:0] tgt);
    upd_pc = a;
    upd_taken = tk;
    upd_target = tgt;
    upd_valid = 1'b1;
    cyc();
    upd_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int exp_n);
    int n = 0;
    while (!bpu_ready && n < 300) begin
      cyc();
      n++;
    end
    chk(tag, 64'(n), 64'(exp_n));
  endtask

  initial begin
    int   n;
    logic pv_seen;
    // Reset and first init walk, with a lookup held during INIT
    cyc();
    cyc();
    chk("rst.ready", 64'(bpu_ready), 64'd0);
    chk("rst.pv", 64'(predict_valid), 64'd0);
    chk("rst.base", base_pc, 64'd0);
    chk("rst.trig", trigger_pc, 64'd0);
    chk("rst.tgt", predict_target, 64'd0);
    reset = 1'b0;
    pc = 64'h8000_0000;
    pc_handshake = 1'b1;
    n = 0;
    pv_seen = 1'b0;
    while (!bpu_ready && n < 300) begin
      cyc();
      n++;
      pv_seen |= predict_valid;
    end
    pc_handshake = 1'b0;
    chk("init.cycles", 64'(n), 64'd64);
    chk("init.pv", 64'(pv_seen), 64'd0);
    chk("init.base", base_pc, 64'd0);

    // Allocate and predict
    upd(64'h8000_0004, 1'b1, 64'h8000_0100);
    lookup("alloc", 64'h8000_0000, 1'b1, 64'h8000_0004, 64'h8000_0100);

    // Unaligned fetch skips lower slot
    upd(64'h8000_0010, 1'b1, 64'h9000);
    lookup("unal.skip", 64'h8000_0014, 1'b0, '0, '0);
    lookup("unal.hit", 64'h8000_0010, 1'b1, 64'h8000_0010, 64'h9000);

    // Counter saturation both ways, target kept on not-taken
    upd(64'h8000_0020, 1'b1, 64'hA000);
    for (int i = 0; i < 3; i++) upd(64'h8000_0020, 1'b1, 64'hA000);
    lookup("ctr.sat3", 64'h8000_0020, 1'b1, 64'h8000_0020, 64'hA000);
    upd(64'h8000_0020, 1'b0, 64'hDEAD);
    lookup("ctr.two", 64'h8000_0020, 1'b1, 64'h8000_0020, 64'hA000);
    upd(64'h8000_0020, 1'b0, 64'hDEAD);
    lookup("ctr.one", 64'h8000_0020, 1'b0, '0, '0);
    for (int i = 0; i < 6; i++) upd(64'h8000_0020, 1'b0, 64'hDEAD);
    lookup("ctr.zero", 64'h8000_0020, 1'b0, '0, '0);
    upd(64'h8000_0020, 1'b1, 64'hB000);
    lookup("ctr.up1", 64'h8000_0020, 1'b0, '0, '0);
    upd(64'h8000_0020, 1'b1, 64'hB000);
    lookup("ctr.up2", 64'h8000_0020, 1'b1, 64'h8000_0020, 64'hB000);

    // Lowest of two taken slots wins
    upd(64'h8000_0000, 1'b1, 64'h7000);
    lookup("lowest", 64'h8000_0000, 1'b1, 64'h8000_0000, 64'h7000);

    // Tag miss via aliasing index, then idle hold
    lookup("tagmiss", 64'h8000_0200, 1'b0, '0, '0);
    cyc();
    chk("idle.pv", 64'(predict_valid), 64'd0);
    chk("idle.base", base_pc, 64'h8000_0200);

    // Flush with same-cycle lookup (pre-flush) and dropped update
    push_exp(64'h8000_0000, 1'b1, 64'h8000_0000, 64'h7000);
    pc = 64'h8000_0000;
    pc_handshake = 1'b1;
    flush_all = 1'b1;
    upd_pc = 64'h8000_0040;
    upd_taken = 1'b1;
    upd_target = 64'h1234;
    upd_valid = 1'b1;
    cyc();
    pc_handshake = 1'b0;
    flush_all = 1'b0;
    upd_valid = 1'b0;
    check_out("flush.lkp");
    chk("flush.ready", 64'(bpu_ready), 64'd0);
    n = 0;
    while (!bpu_ready && n < 300) begin
      if (n == 5) begin
        upd_pc = 64'h8000_0080;
        upd_taken = 1'b1;
        upd_target = 64'h5555;
        upd_valid = 1'b1;
      end
      cyc();
      upd_valid = 1'b0;
      n++;
    end
    chk("flush.cycles", 64'(n), 64'd64);
    lookup("flush.orig", 64'h8000_0000, 1'b0, '0, '0);
    lookup("flush.drop", 64'h8000_0040, 1'b0, '0, '0);
    lookup("flush.initupd", 64'h8000_0080, 1'b0, '0, '0);
    lookup("flush.slot1", 64'h8000_0004, 1'b0, '0, '0);

    // Same-cycle allocation and lookup of one entry
`ifdef BPU_FWD_EN
    push_exp(64'h8000_0004, 1'b1, 64'h8000_0004, 64'h5000);
`else
    push_exp(64'h8000_0004, 1'b0, '0, '0);
`endif
    pc = 64'h8000_0004;
    pc_handshake = 1'b1;
    upd_pc = 64'h8000_0004;
    upd_taken = 1'b1;
    upd_target = 64'h5000;
    upd_valid = 1'b1;
    cyc();
    pc_handshake = 1'b0;
    upd_valid = 1'b0;
    check_out("same");
    lookup("same.after", 64'h8000_0004, 1'b1, 64'h8000_0004, 64'h5000);

    // Reset mid-INIT at walk 30 restarts the walk
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 30; i++) cyc();
    reset = 1'b1;
    cyc();
    last_trig = '0;
    last_tgt = '0;
    chk("rst2.pv", 64'(predict_valid), 64'd0);
    chk("rst2.base", base_pc, 64'd0);
    chk("rst2.trig", trigger_pc, 64'd0);
    chk("rst2.tgt", predict_target, 64'd0);
    reset = 1'b0;
    wait_ready("rst2.cycles", 64);
    lookup("rst2.empty", 64'h8000_0004, 1'b0, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
